lfsr_run_ctrl: RTL and testbench

Sequencer for the 16-bit LFSR/bit-counter datapath. On a start request it issues a programmed number of `sh_en` pulses at a programmable pace. It watches the datapath's `max_tick` to measure the sequence period, detects lock-up (period 1), and reports per-run ones/zeros deltas plus a consistency check. It sits between the top-level control/UI logic and the LFSR instance, and is the only driver of the LFSR's `sh_en`.

---
 rtl/lfsr_run_ctrl_if.sv | 36 +++
 rtl/lfsr_run_ctrl.sv | 160 ++++++++++++++++
 tb/tb_lfsr_run_ctrl.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/lfsr_run_ctrl_if.sv
// Control/status bundle between the UI logic, the LFSR datapath and the run sequencer.
// master = request/datapath side, slave = the sequencer.
interface lfsr_run_ctrl_if #(
    parameter int W      = 16,
    parameter int PACE_W = 8
);
    logic              start;
    logic              abort;
    logic [W-1:0]      run_len;
    logic [PACE_W-1:0] pace;
    logic              max_tick_i;
    logic [W-1:0]      ones_i;
    logic [W-1:0]      zeros_i;
    logic              sh_en;
    logic              busy;
    logic              done;
    logic [W-1:0]      shifts_out;
    logic [W-1:0]      period_out;
    logic              period_vld;
    logic              lockup;
    logic [W-1:0]      ones_d;
    logic [W-1:0]      zeros_d;
    logic              cnt_err;

    modport master (
        output start, abort, run_len, pace, max_tick_i, ones_i, zeros_i,
        input  sh_en, busy, done, shifts_out, period_out, period_vld, lockup,
               ones_d, zeros_d, cnt_err
    );

    modport slave (
        input  start, abort, run_len, pace, max_tick_i, ones_i, zeros_i,
        output sh_en, busy, done, shifts_out, period_out, period_vld, lockup,
               ones_d, zeros_d, cnt_err
    );
endinterface

// File: rtl/lfsr_run_ctrl.sv
// Run sequencer for the LFSR/bit-counter datapath: paced sh_en bursts, period and
// lock-up detection, and per-run ones/zeros deltas with a consistency flag.
module lfsr_run_ctrl #(
    parameter int W      = 16,
    parameter int PACE_W = 8
) (
    input  logic          clk,
    input  logic          reset,
    lfsr_run_ctrl_if.slave bus
);
    typedef enum logic [2:0] {IDLE, SHIFT, GAP, SETTLE, DONE} state_e;

    state_e            state_q, state_d;
    logic [W-1:0]      len_q, len_d;
    logic [PACE_W-1:0] pace_q, pace_d;
    logic [PACE_W-1:0] gap_q, gap_d;
    logic [W-1:0]      shift_cnt_q, shift_cnt_d;
    logic [W-1:0]      base_ones_q, base_ones_d;
    logic [W-1:0]      base_zeros_q, base_zeros_d;
    logic              sh_en_q;
    logic [W-1:0]      shifts_out_q, shifts_out_d;
    logic [W-1:0]      period_q, period_d;
    logic              period_vld_q, period_vld_d;
    logic              lockup_q, lockup_d;
    logic [W-1:0]      ones_d_q, ones_d_d;
    logic [W-1:0]      zeros_d_q, zeros_d_d;
    logic              cnt_err_q, cnt_err_d;

    logic accept;
    logic shift_fire;
    logic last_shift;

    assign accept     = (state_q == IDLE) && bus.start;
    // abort masks the shift of the very cycle it arrives in
    assign shift_fire = (state_q == SHIFT) && !bus.abort;
    assign last_shift = (shift_cnt_q + W'(1)) == len_q;

    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // NOTE: each comb block assigns defaults first so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.start) state_d = (bus.run_len == '0) ? DONE : SHIFT;
            SHIFT:   if (bus.abort || last_shift) state_d = SETTLE;
                     else if (pace_q != '0)       state_d = GAP;
            GAP:     if (bus.abort)               state_d = SETTLE;
                     else if (gap_q == PACE_W'(1)) state_d = SHIFT;
            SETTLE:  state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.sh_en = shift_fire;
        bus.busy  = (state_q != IDLE);
        bus.done  = (state_q == DONE);
    end

    always_comb begin
        len_d        = len_q;
        pace_d       = pace_q;
        gap_d        = gap_q;
        shift_cnt_d  = shift_cnt_q;
        base_ones_d  = base_ones_q;
        base_zeros_d = base_zeros_q;
        shifts_out_d = shifts_out_q;
        period_d     = period_q;
        period_vld_d = period_vld_q;
        lockup_d     = lockup_q;
        ones_d_d     = ones_d_q;
        zeros_d_d    = zeros_d_q;
        cnt_err_d    = cnt_err_q;

        if (accept) begin
            len_d        = bus.run_len;
            pace_d       = bus.pace;
            base_ones_d  = bus.ones_i;
            base_zeros_d = bus.zeros_i;
            shift_cnt_d  = '0;
            period_d     = '0;
            period_vld_d = 1'b0;
            lockup_d     = 1'b0;
            if (bus.run_len == '0) begin
                shifts_out_d = '0;
                ones_d_d     = '0;
                zeros_d_d    = '0;
                cnt_err_d    = 1'b0;
            end
        end

        if (shift_fire) begin
            shift_cnt_d = shift_cnt_q + W'(1);
            if (!last_shift) gap_d = pace_q;
        end else if (state_q == GAP) begin
            gap_d = gap_q - PACE_W'(1);
        end

        // The datapath's tick for shift N lands one cycle after that shift.
        if (sh_en_q && bus.max_tick_i && !period_vld_q) begin
            period_d     = shift_cnt_q;
            period_vld_d = 1'b1;
            lockup_d     = (shift_cnt_q == W'(1));
        end

        if (state_q == SETTLE) begin
            shifts_out_d = shift_cnt_q;
            ones_d_d     = bus.ones_i - base_ones_q;
            zeros_d_d    = bus.zeros_i - base_zeros_q;
            cnt_err_d    = (ones_d_d + zeros_d_d) != shift_cnt_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            len_q        <= '0;
            pace_q       <= '0;
            gap_q        <= '0;
            shift_cnt_q  <= '0;
            base_ones_q  <= '0;
            base_zeros_q <= '0;
            sh_en_q      <= 1'b0;
            shifts_out_q <= '0;
            period_q     <= '0;
            period_vld_q <= 1'b0;
            lockup_q     <= 1'b0;
            ones_d_q     <= '0;
            zeros_d_q    <= '0;
            cnt_err_q    <= 1'b0;
        end else begin
            len_q        <= len_d;
            pace_q       <= pace_d;
            gap_q        <= gap_d;
            shift_cnt_q  <= shift_cnt_d;
            base_ones_q  <= base_ones_d;
            base_zeros_q <= base_zeros_d;
            sh_en_q      <= shift_fire;
            shifts_out_q <= shifts_out_d;
            period_q     <= period_d;
            period_vld_q <= period_vld_d;
            lockup_q     <= lockup_d;
            ones_d_q     <= ones_d_d;
            zeros_d_q    <= zeros_d_d;
            cnt_err_q    <= cnt_err_d;
        end
    end

    assign bus.shifts_out = shifts_out_q;
    assign bus.period_out = period_q;
    assign bus.period_vld = period_vld_q;
    assign bus.lockup     = lockup_q;
    assign bus.ones_d     = ones_d_q;
    assign bus.zeros_d    = zeros_d_q;
    assign bus.cnt_err    = cnt_err_q;
endmodule

// File: tb/tb_lfsr_run_ctrl.sv
// Bench for lfsr_run_ctrl: a stub datapath with programmable period, plus a run model
// that predicts the sh_en schedule and every result from the run parameters alone.
module tb_lfsr_run_ctrl;
    localparam int W      = 16;
    localparam int PACE_W = 8;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    lfsr_run_ctrl_if #(.W(W), .PACE_W(PACE_W)) bus ();
    lfsr_run_ctrl #(.W(W), .PACE_W(PACE_W)) u_dut (.clk(clk), .reset(reset), .bus(bus));

    int n_checks = 0;
    int n_fail   = 0;

    // Stub datapath: stub_pos counts every shift ever issued; tick after shifts that
    // complete a multiple of stub_per; the shift at index drop_at updates no counter.
    int   stub_pos   = 0;
    int   tot_ones   = 0;
    int   tot_zeros  = 0;
    int   stub_per   = 5;
    int   drop_at    = -1;
    bit   all_ones   = 1'b0;
    bit   tick_noise = 1'b0;
    logic tick_q     = 1'b0;
    logic [W-1:0] ones_base  = '0;
    logic [W-1:0] zeros_base = '0;

    assign bus.max_tick_i = tick_q;
    assign bus.ones_i     = ones_base + W'(tot_ones);
    assign bus.zeros_i    = zeros_base + W'(tot_zeros);

    always @(posedge clk) begin
        if (bus.sh_en) begin
            if (stub_pos != drop_at) begin
                if (all_ones || $urandom_range(0, 1) == 1) tot_ones <= tot_ones + 1;
                else                                      tot_zeros <= tot_zeros + 1;
            end
            tick_q   <= ((stub_pos + 1) % stub_per) == 0;
            stub_pos <= stub_pos + 1;
        end else begin
            // spurious ticks outside the post-shift cycle must be ignored
            tick_q <= tick_noise && ($urandom_range(0, 3) == 0);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One complete run; abort_k>0 raises abort on the cycle of the k-th shift.
    task automatic do_run(input int len, input int pc, input int abort_k, input bit drop);
        int  n, p0, ones0, zeros0, done_c, abort_c, exp_per;
        bit  aborted, exp_vld, exp_sh, exp_err;
        aborted = (abort_k >= 1) && (abort_k <= len);
        n       = aborted ? abort_k - 1 : len;
        abort_c = aborted ? 1 + (abort_k - 1) * (pc + 1) : -1;
        if (len == 0)     done_c = 1;
        else if (aborted) done_c = abort_c + 2;
        else              done_c = 1 + (len - 1) * (pc + 1) + 2;

        @(negedge clk);
        p0      = stub_pos;
        ones0   = tot_ones;
        zeros0  = tot_zeros;
        drop_at = drop ? p0 + 2 : -1;
        exp_err = drop && (n >= 3);
        bus.start   = 1'b1;
        bus.run_len = W'(len);
        bus.pace    = PACE_W'(pc);
        @(negedge clk);

        for (int c = 1; c <= done_c + 1; c++) begin
            bus.abort = (c == abort_c);
            // start pulses while busy or in DONE must not queue a run
            bus.start   = (c == done_c) || (c == 2 && done_c > 2);
            bus.run_len = W'($urandom_range(1, 50));
            #1;
            exp_sh = ((c - 1) % (pc + 1) == 0) && ((c - 1) / (pc + 1) < n);
            check("sh_en", bus.sh_en, exp_sh);
            check("busy", bus.busy, c <= done_c);
            check("done", bus.done, c == done_c);
            @(negedge clk);
        end
        bus.abort = 1'b0;
        bus.start = 1'b0;
        drop_at   = -1;

        exp_vld = 1'b0;
        exp_per = 0;
        for (int i = 1; i <= n; i++)
            if (!exp_vld && ((p0 + i) % stub_per) == 0) begin
                exp_vld = 1'b1;
                exp_per = i;
            end

        check("busy_after", bus.busy, 0);
        check("shifts_out", bus.shifts_out, n);
        check("period_vld", bus.period_vld, exp_vld);
        if (exp_vld) check("period_out", bus.period_out, exp_per);
        check("lockup", bus.lockup, exp_vld && exp_per == 1);
        check("ones_d", bus.ones_d, W'(tot_ones - ones0));
        check("zeros_d", bus.zeros_d, W'(tot_zeros - zeros0));
        check("cnt_err", bus.cnt_err, exp_err);
    endtask

    task automatic reset_mid_gap();
        stub_per = 100;
        @(negedge clk);
        bus.start   = 1'b1;
        bus.run_len = W'(4);
        bus.pace    = PACE_W'(3);
        @(negedge clk);
        bus.start = 1'b0;
        #1 check("rst_first_shift", bus.sh_en, 1);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("rst_sh_en", bus.sh_en, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_shifts_out", bus.shifts_out, 0);
        check("rst_ones_d", bus.ones_d, 0);
        check("rst_cnt_err", bus.cnt_err, 0);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        bus.start   = 1'b0;
        bus.abort   = 1'b0;
        bus.run_len = '0;
        bus.pace    = '0;
        #1;
        check("reset_busy", bus.busy, 0);
        check("reset_sh_en", bus.sh_en, 0);
        check("reset_done", bus.done, 0);
        check("reset_period_vld", bus.period_vld, 0);
        check("reset_shifts_out", bus.shifts_out, 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;

        stub_per = 5;   do_run(12, 0, 0, 1'b0);   // back-to-back, period 5
        stub_per = 100; do_run(4, 3, 0, 1'b0);    // paced, no tick
        stub_per = 1;   do_run(6, 1, 0, 1'b0);    // lock-up
        stub_per = 7;   do_run(100, 0, 10, 1'b0); // abort on 10th shift

        all_ones  = 1'b1;
        ones_base = 16'hFFFE - W'(tot_ones);
        do_run(5, 1, 0, 1'b0);                    // ones count wraps
        all_ones  = 1'b0;
        do_run(6, 0, 0, 1'b1);                    // dropped count

        reset_mid_gap();
        stub_per = 3;   do_run(5, 2, 0, 1'b0);
        do_run(0, 2, 0, 1'b0);                    // empty run

        tick_noise = 1'b1;
        for (int r = 0; r < 25; r++) begin
            int len, pc, ak;
            len      = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 20);
            pc       = $urandom_range(0, 3);
            stub_per = $urandom_range(1, 7);
            ak       = ($urandom_range(0, 2) == 0 && len > 0) ? $urandom_range(1, len) : 0;
            do_run(len, pc, ak, $urandom_range(0, 3) == 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
